// File: rtl/segment_decoder_monitor.sv
// Watches a 7-segment bus, waits for the pattern to hold steady for STABLE_TICKS
// frame ticks, then reports the decoded hex nibble on a valid/ready output.
module segment_decoder_monitor #(
  parameter int STABLE_TICKS = 4,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       tick,
  input  logic [6:0] seg_in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_hex,
  output logic       out_blank,
  output logic       out_error,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    EMIT   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_TICKS);

  state_t           state_q, state_d;
  logic [6:0]       seg_s_q;
  logic [6:0]       cand_q, cand_d;
  logic [6:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [3:0]       out_hex_q, out_hex_d;
  logic             out_blank_q, out_blank_d;
  logic             out_error_q, out_error_d;
  logic             busy_q, busy_d;

  // Result layout is {error, blank, hex}; anything off the glyph table is an error.
  function automatic logic [5:0] decode(input logic [6:0] pat);
    logic [5:0] r;
    case (pat)
      7'h3F:   r = {2'b00, 4'h0};
      7'h06:   r = {2'b00, 4'h1};
      7'h5B:   r = {2'b00, 4'h2};
      7'h4F:   r = {2'b00, 4'h3};
      7'h66:   r = {2'b00, 4'h4};
      7'h6D:   r = {2'b00, 4'h5};
      7'h7D:   r = {2'b00, 4'h6};
      7'h07:   r = {2'b00, 4'h7};
      7'h7F:   r = {2'b00, 4'h8};
      7'h6F:   r = {2'b00, 4'h9};
      7'h77:   r = {2'b00, 4'hA};
      7'h7C:   r = {2'b00, 4'hB};
      7'h39:   r = {2'b00, 4'hC};
      7'h5E:   r = {2'b00, 4'hD};
      7'h79:   r = {2'b00, 4'hE};
      7'h71:   r = {2'b00, 4'hF};
      7'h00:   r = {2'b01, 4'h0};
      default: r = {2'b10, 4'h0};
    endcase
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    out_hex_d   = out_hex_q;
    out_blank_d = out_blank_q;
    out_error_d = out_error_q;

    // Dropping enable abandons any settle or pending report without touching last.
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (seg_s_q != last_q) begin
            state_d = SETTLE;
            cand_d  = seg_s_q;
            cnt_d   = '0;
          end
        end
        SETTLE: begin
          if (seg_s_q != cand_q) begin
            cand_d = seg_s_q;
            cnt_d  = '0;
          end else if (tick) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == STABLE_CNT) begin
              state_d = EMIT;
              {out_error_d, out_blank_d, out_hex_d} = decode(cand_q);
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            last_d  = cand_q;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    out_valid_d = (state_d == EMIT);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      seg_s_q     <= 7'h00;
      cand_q      <= 7'h00;
      last_q      <= 7'h00;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_hex_q   <= 4'h0;
      out_blank_q <= 1'b0;
      out_error_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      seg_s_q     <= seg_in;
      cand_q      <= cand_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_hex_q   <= out_hex_d;
      out_blank_q <= out_blank_d;
      out_error_q <= out_error_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_hex   = out_hex_q;
  assign out_blank = out_blank_q;
  assign out_error = out_error_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_segment_decoder_monitor.sv
// Randomized bench for segment_decoder_monitor: drives a wandering segment bus,
// ticks, ready and enable, and compares every cycle against a behavioural model.
module tb_segment_decoder_monitor;

  localparam int STABLE = 4;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       tick;
  logic [6:0] seg_in;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_hex;
  logic       out_blank;
  logic       out_error;
  logic       busy;

  int check_count;
  int error_count;

  segment_decoder_monitor #(.STABLE_TICKS(STABLE), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .tick      (tick),
    .seg_in    (seg_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_hex   (out_hex),
    .out_blank (out_blank),
    .out_error (out_error),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: a display watcher that remembers what it last reported,
  // what it is currently watching, and how many steady ticks it has seen.
  logic [6:0] m_sampled;
  logic [6:0] m_watched;
  logic [6:0] m_reported;
  int         m_steady;
  bit         m_watching;
  bit         m_reporting;
  logic [3:0] m_hex;
  bit         m_blank;
  bit         m_error;
  int         reports;

  int seg_hold;
  int en_hold;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_sampled   = 7'h00;
    m_watched   = 7'h00;
    m_reported  = 7'h00;
    m_steady    = 0;
    m_watching  = 0;
    m_reporting = 0;
    m_hex       = 4'h0;
    m_blank     = 0;
    m_error     = 0;
  endtask

  task automatic modelLatch(input logic [6:0] pat);
    m_hex   = 4'h0;
    m_blank = (pat == 7'h00);
    m_error = (pat != 7'h00);
    for (int i = 0; i < 16; i++) begin
      if (glyph[i] == pat) begin
        m_hex   = 4'(i);
        m_error = 0;
      end
    end
  endtask

  // One clock edge of the model, using the inputs that were stable before it.
  task automatic modelStep();
    logic [6:0] seen;
    seen = m_sampled;
    if (!enable) begin
      m_watching  = 0;
      m_reporting = 0;
      m_steady    = 0;
    end else if (m_reporting) begin
      if (out_ready) begin
        m_reported  = m_watched;
        m_reporting = 0;
        reports++;
      end
    end else if (m_watching) begin
      if (seen != m_watched) begin
        m_watched = seen;
        m_steady  = 0;
      end else if (tick) begin
        m_steady++;
        if (m_steady == STABLE) begin
          m_watching  = 0;
          m_reporting = 1;
          modelLatch(m_watched);
        end
      end
    end else if (seen != m_reported) begin
      m_watching = 1;
      m_watched  = seen;
      m_steady   = 0;
    end
    m_sampled = seg_in;
  endtask

  task automatic compareAll();
    checkOutput("out_valid", {7'b0, out_valid}, {7'b0, m_reporting});
    checkOutput("out_hex",   {4'b0, out_hex},   {4'b0, m_hex});
    checkOutput("out_blank", {7'b0, out_blank}, {7'b0, m_blank});
    checkOutput("out_error", {7'b0, out_error}, {7'b0, m_error});
    checkOutput("busy",      {7'b0, busy},      {7'b0, (m_watching || m_reporting)});
  endtask

  task automatic applyStimulus();
    if (seg_hold == 0) begin
      case ($urandom_range(0, 9))
        7:       seg_in = 7'h00;
        8:       seg_in = 7'($urandom_range(0, 127));
        9:       seg_in = seg_in;
        default: seg_in = glyph[$urandom_range(0, 15)];
      endcase
      seg_hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(20, 70);
    end else begin
      seg_hold--;
    end
    if (en_hold == 0) begin
      enable  = ($urandom_range(0, 19) != 0);
      en_hold = enable ? $urandom_range(20, 120) : $urandom_range(1, 5);
    end else begin
      en_hold--;
    end
    out_ready = ($urandom_range(0, 3) != 0);
    tick      = ($urandom_range(0, 5) == 0);
  endtask

  task automatic applyReset();
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("reset_valid", {7'b0, out_valid}, 8'h00);
    checkOutput("reset_busy",  {7'b0, busy},      8'h00);
    checkOutput("reset_hex",   {4'b0, out_hex},   8'h00);
    checkOutput("reset_blank", {7'b0, out_blank}, 8'h00);
    checkOutput("reset_error", {7'b0, out_error}, 8'h00);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    check_count = 0;
    error_count = 0;
    reports     = 0;
    seg_hold    = 0;
    en_hold     = 0;
    reset       = 1'b0;
    enable      = 1'b1;
    tick        = 1'b0;
    seg_in      = 7'h00;
    out_ready   = 1'b1;

    @(negedge clk);
    applyReset();

    // Blank bus at power-up: never reported, never busy.
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      compareAll();
      tick = (c % 8 == 0);
      @(posedge clk);
      modelStep();
    end

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      compareAll();
      if ($urandom_range(0, 299) == 0) applyReset();
      applyStimulus();
      @(posedge clk);
      modelStep();
    end

    @(negedge clk);
    compareAll();
    checkOutput("reports_seen", {7'b0, (reports > 10)}, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
